// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer execution unit. Base ALU ops finish in one cycle;
// multiply/divide iterate one bit per cycle over WIDTH cycles.
module alu_mc #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_flag,
   output logic             overflow_flag,
   output logic             zero_flag
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_q, state_d;
   logic                 accept;
   logic [CW-1:0]        cnt_q;
   logic [2:0]           op_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [2*WIDTH-1:0]   acc_q;

   // Signedness of an operand for a given M-extension funct3.
   function automatic logic op_signed(input logic [2:0] f, input logic is_a);
      if (f[2]) return ~f[0];
      if (is_a) return (f[1:0] == 2'b01) || (f[1:0] == 2'b10);
      return f[1:0] == 2'b01;
   endfunction

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the case leaves it unassigned and infers a latch.
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = opcode[4] ? BUSY : DONE;
         end
         BUSY: begin
            if (cnt_q == '0) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_d = in_valid ? (opcode[4] ? BUSY : DONE) : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;

   logic [CW-1:0]    shamt;
   logic [WIDTH:0]   add_sum, sub_sum;
   logic [WIDTH-1:0] base_res;
   logic             base_c, base_v, base_known;

   assign shamt   = b[CW-1:0];
   assign add_sum = {1'b0, a} + {1'b0, b};
   assign sub_sum = {1'b0, a} - {1'b0, b};

   always_comb begin
      base_res   = '0;
      base_c     = 1'b0;
      base_v     = 1'b0;
      base_known = 1'b1;
      case (opcode[3:0])
         4'b0000: begin
            base_res = add_sum[WIDTH-1:0];
            base_c   = add_sum[WIDTH];
            base_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
         end
         4'b1000: begin
            // The high bit of the widened difference is the borrow.
            base_res = sub_sum[WIDTH-1:0];
            base_c   = sub_sum[WIDTH];
            base_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
         end
         4'b0010: base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         4'b0011: base_res = {{(WIDTH-1){1'b0}}, a < b};
         4'b0001: base_res = a << shamt;
         4'b0101: base_res = a >> shamt;
         4'b1101: base_res = $signed(a) >>> shamt;
         4'b0111: base_res = a & b;
         4'b0110: base_res = a | b;
         4'b0100: base_res = a ^ b;
         default: base_known = 1'b0;
      endcase
   end

   logic [WIDTH-1:0] in_mag_a, in_mag_b, mag_a, mag_b;
   logic             sign_a, sign_b, neg_res, div_zero, div_ovf;

   assign in_mag_a = (op_signed(opcode[2:0], 1'b1) & a[WIDTH-1]) ? -a : a;
   assign in_mag_b = (op_signed(opcode[2:0], 1'b0) & b[WIDTH-1]) ? -b : b;

   assign sign_a   = op_signed(op_q, 1'b1) & a_q[WIDTH-1];
   assign sign_b   = op_signed(op_q, 1'b0) & b_q[WIDTH-1];
   assign mag_a    = sign_a ? -a_q : a_q;
   assign mag_b    = sign_b ? -b_q : b_q;
   assign neg_res  = (op_q[2] & op_q[1]) ? sign_a : (sign_a ^ sign_b);
   assign div_zero = (b_q == '0);
   assign div_ovf  = op_q[2] & ~op_q[0] & (a_q == {1'b1, {(WIDTH-1){1'b0}}}) & (&b_q);

   logic [WIDTH:0]     msum, part;
   logic [WIDTH-1:0]   dsub;
   logic               ge;
   logic [2*WIDTH-1:0] iter_next;

   // Multiply: add |a| into the upper half when the multiplier LSB is set, then
   // shift right. Divide: shift the dividend into the partial remainder and
   // subtract the divisor when it fits.
   assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a} : '0);
   assign part = acc_q[2*WIDTH-1:WIDTH-1];
   assign ge   = part >= {1'b0, mag_b};
   assign dsub = part[WIDTH-1:0] - mag_b;
   assign iter_next = !op_q[2] ? {msum, acc_q[WIDTH-1:1]} :
                      ge       ? {dsub, acc_q[WIDTH-2:0], 1'b1} :
                                 {part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem, m_res;
   logic               m_v;

   always_comb begin
      prod  = neg_res ? -iter_next : iter_next;
      quo   = neg_res ? -iter_next[WIDTH-1:0] : iter_next[WIDTH-1:0];
      rem   = neg_res ? -iter_next[2*WIDTH-1:WIDTH] : iter_next[2*WIDTH-1:WIDTH];
      m_res = '0;
      m_v   = 1'b0;
      if (!op_q[2]) begin
         m_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      end else if (op_q[1]) begin
         m_res = div_zero ? a_q : rem;
         m_v   = div_ovf;
      end else begin
         m_res = div_zero ? '1 : quo;
         m_v   = div_ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         op_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         acc_q         <= '0;
         result        <= '0;
         carry_flag    <= 1'b0;
         overflow_flag <= 1'b0;
         zero_flag     <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         op_q  <= opcode[2:0];
         cnt_q <= CW'(WIDTH - 1);
         acc_q <= opcode[2] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
         if (!opcode[4]) begin
            result        <= base_res;
            carry_flag    <= base_c;
            overflow_flag <= base_v;
            zero_flag     <= base_known && (base_res == '0);
         end
      end else if (state_q == BUSY) begin
         acc_q <= iter_next;
         if (cnt_q == '0) begin
            result        <= m_res;
            carry_flag    <= 1'b0;
            overflow_flag <= m_v;
            zero_flag     <= (m_res == '0);
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table at WIDTH=64 plus
// hand-written handshake, reset and WIDTH=8 sequences.
module tb_alu_mc;
   localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MN = 64'h8000_0000_0000_0000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, out_valid, out_ready, cf, vf, zf;
   logic [63:0] a, b, result;
   logic [4:0]  opcode;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, cf8, vf8, zf8;
   logic [7:0]  a8, b8, result8;
   logic [4:0]  opcode8;

   alu_mc #(.WIDTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry_flag(cf), .overflow_flag(vf), .zero_flag(zf)
   );

   alu_mc #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .opcode(opcode8), .out_valid(out_valid8), .out_ready(out_ready8),
      .result(result8), .carry_flag(cf8), .overflow_flag(vf8), .zero_flag(zf8)
   );

   typedef struct {
      logic [4:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      logic [2:0]  cvz;
      int          lat;
   } vec_t;

   vec_t vt[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [4:0] op, input logic [63:0] x, input logic [63:0] y,
                               input logic [63:0] r, input logic [2:0] cvz, input int lat);
      vec_t v;
      v.op = op; v.a = x; v.b = y; v.res = r; v.cvz = cvz; v.lat = lat;
      vt.push_back(v);
   endfunction

   // Issue one op, report result/flags and the edge count from accept to out_valid, then retire it.
   task automatic op64(input logic [4:0] op, input logic [63:0] x, input logic [63:0] y,
                       output logic [63:0] r, output logic [2:0] cvz, output int lat);
      @(negedge clk);
      in_valid = 1'b1; opcode = op; a = x; b = y; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; a = ~x; b = ~y;
      lat = 1;
      while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      r = result; cvz = {cf, vf, zf};
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
   endtask

   task automatic op8(input logic [4:0] op, input logic [7:0] x, input logic [7:0] y,
                      output logic [7:0] r, output logic [2:0] cvz, output int lat);
      @(negedge clk);
      in_valid8 = 1'b1; opcode8 = op; a8 = x; b8 = y; out_ready8 = 1'b0;
      @(posedge clk); #1;
      in_valid8 = 1'b0; a8 = ~x; b8 = ~y;
      lat = 1;
      while (!out_valid8 && lat < 200) begin @(posedge clk); #1; lat++; end
      r = result8; cvz = {cf8, vf8, zf8};
      @(negedge clk); out_ready8 = 1'b1;
      @(posedge clk); #1; out_ready8 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] r;
      logic [7:0]  r8;
      logic [2:0]  cvz;
      int          lat;
      logic        stale;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; opcode = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; opcode8 = '0;

      //  op        a                        b                        result                  c v z  lat
      add(5'b00000, M1,                      64'd1,                   64'd0,                  3'b101, 1);
      add(5'b01000, 64'd5,                   64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 3'b100, 1);
      add(5'b01101, MN,                      64'd63,                  M1,                     3'b000, 1);
      add(5'b00010, M1,                      64'd1,                   64'd1,                  3'b000, 1);
      add(5'b00011, M1,                      64'd1,                   64'd0,                  3'b001, 1);
      add(5'b00000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                   MN,                     3'b010, 1);
      add(5'b01000, MN,                      64'd1,                   64'h7FFF_FFFF_FFFF_FFFF, 3'b010, 1);
      add(5'b01000, 64'd9,                   64'd9,                   64'd0,                  3'b001, 1);
      add(5'b00001, 64'd1,                   64'h41,                  64'd2,                  3'b000, 1);
      add(5'b00101, MN,                      64'd4,                   64'h0800_0000_0000_0000, 3'b000, 1);
      add(5'b00111, 64'hF0F0,                64'hFF00,                64'hF000,               3'b000, 1);
      add(5'b00110, 64'hF0F0,                64'hFF00,                64'hFFF0,               3'b000, 1);
      add(5'b00100, 64'hF0F0,                64'hFF00,                64'h0FF0,               3'b000, 1);
      add(5'b01111, 64'd5,                   64'd3,                   64'd0,                  3'b000, 1);
      add(5'b10000, 64'd3,                   64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4, 3'b000, 65);
      add(5'b10011, M1,                      M1,                      64'hFFFF_FFFF_FFFF_FFFE, 3'b000, 65);
      add(5'b10001, M1,                      M1,                      64'd0,                  3'b001, 65);
      add(5'b10010, M1,                      64'd2,                   M1,                     3'b000, 65);
      add(5'b10001, MN,                      MN,                      64'h4000_0000_0000_0000, 3'b000, 65);
      add(5'b10100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 3'b000, 65);
      add(5'b10110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   M1,                     3'b000, 65);
      add(5'b10101, 64'h1234,                64'd0,                   M1,                     3'b000, 65);
      add(5'b10111, 64'h1234,                64'd0,                   64'h1234,               3'b000, 65);
      add(5'b10100, MN,                      M1,                      MN,                     3'b010, 65);
      add(5'b10110, MN,                      M1,                      64'd0,                  3'b011, 65);
      add(5'b10100, 64'd7,                   64'd0,                   M1,                     3'b000, 65);
      add(5'b10110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0,                   64'hFFFF_FFFF_FFFF_FFF9, 3'b000, 65);
      add(5'b10101, 64'd100,                 64'd7,                   64'd14,                 3'b000, 65);
      add(5'b10111, 64'd100,                 64'd7,                   64'd2,                  3'b000, 65);
      add(5'b11100, 64'd20,                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 3'b000, 65);
      add(5'b10110, 64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 64'd1,                  3'b000, 65);

      #12;
      check("reset out_valid", {63'd0, out_valid}, 64'd0);
      check("reset result", result, 64'd0);
      check("reset flags", {61'd0, cf, vf, zf}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      #1 check("in_ready after reset", {63'd0, in_ready}, 64'd1);

      foreach (vt[i]) begin
         op64(vt[i].op, vt[i].a, vt[i].b, r, cvz, lat);
         check($sformatf("vec%0d op%b result", i, vt[i].op), r, vt[i].res);
         check($sformatf("vec%0d op%b c/v/z", i, vt[i].op), {61'd0, cvz}, {61'd0, vt[i].cvz});
         check($sformatf("vec%0d op%b latency", i, vt[i].op), 64'(lat), 64'(vt[i].lat));
      end

      // Reset in the middle of a DIVU; the in-flight result must never appear.
      @(negedge clk);
      in_valid = 1'b1; opcode = 5'b10101; a = 64'd100; b = 64'd7;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset out_valid", {63'd0, out_valid}, 64'd0);
      check("midreset result", result, 64'd0);
      check("midreset flags", {61'd0, cf, vf, zf}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      #1 check("midreset in_ready", {63'd0, in_ready}, 64'd1);
      stale = 1'b0;
      repeat (70) begin @(posedge clk); #1 if (out_valid) stale = 1'b1; end
      check("midreset no stale result", {63'd0, stale}, 64'd0);
      op64(5'b00000, 64'd1, 64'd1, r, cvz, lat);
      check("post-reset ADD result", r, 64'd2);
      check("post-reset ADD latency", 64'(lat), 64'd1);

      // Stalled output after a MUL, then retire together with a new ADD.
      @(negedge clk);
      in_valid = 1'b1; opcode = 5'b10000; a = 64'd6; b = 64'd7; out_ready = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0; a = '0; b = '0;
      lat = 1;
      while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      check("stall MUL latency", 64'(lat), 64'd65);
      check("stall MUL result", result, 64'd42);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("stall%0d out_valid", k), {63'd0, out_valid}, 64'd1);
         check($sformatf("stall%0d result", k), result, 64'd42);
         check($sformatf("stall%0d in_ready", k), {63'd0, in_ready}, 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; opcode = 5'b00000; a = 64'd2; b = 64'd3;
      #1 check("retire+accept in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
      check("retire+accept out_valid", {63'd0, out_valid}, 64'd1);
      check("retire+accept result", result, 64'd5);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      check("retired to idle", {63'd0, out_valid}, 64'd0);

      // Back-to-back base ops with out_ready held high.
      @(negedge clk); in_valid = 1'b1; opcode = 5'b00000; a = 64'd10; b = 64'd20;
      @(posedge clk); #1;
      check("b2b first result", result, 64'd30);
      @(negedge clk); opcode = 5'b01000; a = 64'd50; b = 64'd8;
      @(posedge clk); #1;
      check("b2b second valid", {63'd0, out_valid}, 64'd1);
      check("b2b second result", result, 64'd42);
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      check("b2b drained", {63'd0, out_valid}, 64'd0);
      out_ready = 1'b0;

      // WIDTH=8: DIVU then REMU accepted on the retire edge, then base/special cases.
      @(negedge clk); in_valid8 = 1'b1; opcode8 = 5'b10101; a8 = 8'd200; b8 = 8'd7;
      @(posedge clk); #1 in_valid8 = 1'b0;
      lat = 1;
      while (!out_valid8 && lat < 200) begin @(posedge clk); #1; lat++; end
      check("w8 DIVU latency", 64'(lat), 64'd9);
      check("w8 DIVU result", 64'(result8), 64'd28);
      @(negedge clk); out_ready8 = 1'b1; in_valid8 = 1'b1; opcode8 = 5'b10111; a8 = 8'd200; b8 = 8'd7;
      @(posedge clk); #1 in_valid8 = 1'b0; out_ready8 = 1'b0;
      lat = 1;
      while (!out_valid8 && lat < 200) begin @(posedge clk); #1; lat++; end
      check("w8 REMU b2b latency", 64'(lat), 64'd9);
      check("w8 REMU result", 64'(result8), 64'd4);
      @(negedge clk); out_ready8 = 1'b1;
      @(posedge clk); #1 out_ready8 = 1'b0;
      op8(5'b00001, 8'd1, 8'h0B, r8, cvz, lat);
      check("w8 SLL result", 64'(r8), 64'd8);
      check("w8 SLL latency", 64'(lat), 64'd1);
      op8(5'b10100, 8'h80, 8'hFF, r8, cvz, lat);
      check("w8 DIV ovf result", 64'(r8), 64'h80);
      check("w8 DIV ovf flags", 64'(cvz), 64'b010);
      op8(5'b10001, 8'h80, 8'h80, r8, cvz, lat);
      check("w8 MULH result", 64'(r8), 64'h40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
